// File: rtl/key_event_queue.sv
// key_event_queue: turns rising edges of the debounced key level vector into
// 5-bit key-index events and buffers them in a show-ahead FIFO behind a
// valid/ready port. Keys that cannot be queued wait in a per-key pending
// vector and drain lowest-index-first as FIFO space frees.
// Optional release events are enabled by defining KEY_RELEASE_EVT_EN.
module key_event_queue #(
  parameter int unsigned NKEYS = 25,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic [NKEYS-1:0] btn_ok,
  input  logic             key_ready,
  input  logic             clr_ovf,
  output logic             key_valid,
  output logic [5:0]       key_code,
  output logic [CNT_W-1:0] fifo_count,
  output logic             ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 6;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Lowest set bit position of a key vector (0 when empty).
  function automatic logic [4:0] lowest_idx(input logic [NKEYS-1:0] v);
    logic [NKEYS-1:0] t;
    logic [4:0]       r;
    logic             found;
    t     = v;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NKEYS); i++) begin
      if (t[0] && !found) begin
        r     = 5'(i);
        found = 1'b1;
      end
      t = t >> 1;
    end
    return r;
  endfunction

  logic [CW-1:0]    mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_ptr_d, wr_ptr_d;
  logic [CNT_W-1:0] count_d;
  logic [NKEYS-1:0] prev, pend, pend_d, rise, merge, req_p;
  logic             armed, pop, push_ok, push, ovf_set, ovf_d, valid_d;
  logic [CW-1:0]    wdata, head_d;
  logic [4:0]       sel_p;
`ifdef KEY_RELEASE_EVT_EN
  logic [NKEYS-1:0] pend_rel, pend_rel_d, fall, cancel_p, cancel_r, req_r;
  logic [4:0]       sel_r;
`endif

  // Level edges; suppressed until the first post-reset sample of btn_ok.
  always_comb begin
    rise = armed ? (btn_ok & ~prev) : '0;
`ifdef KEY_RELEASE_EVT_EN
    fall = armed ? (~btn_ok & prev) : '0;
`endif
  end

  // Pending arbitration, FIFO bookkeeping and next head entry.
  always_comb begin
    pop     = key_valid & key_ready;
    push_ok = (fifo_count != FULL_CNT) | pop;
    merge   = rise & pend;
    push    = 1'b0;
    wdata   = '0;
`ifdef KEY_RELEASE_EVT_EN
    // A press and its release still pending cancel each other out.
    cancel_p   = fall & pend;
    cancel_r   = rise & pend_rel;
    req_p      = (pend & ~cancel_p) | (rise & ~cancel_r);
    req_r      = (pend_rel & ~cancel_r) | (fall & ~cancel_p);
    ovf_set    = |(merge | cancel_p | cancel_r | (fall & pend_rel));
    sel_r      = lowest_idx(req_r);
    pend_rel_d = req_r;
`else
    req_p   = pend | rise;
    ovf_set = |merge;
`endif
    sel_p  = lowest_idx(req_p);
    pend_d = req_p;

    if (push_ok && (req_p != '0)) begin
      push   = 1'b1;
      wdata  = {1'b0, sel_p};
      pend_d = req_p & ~(NKEYS'(1) << sel_p);
    end
`ifdef KEY_RELEASE_EVT_EN
    else if (push_ok && (req_r != '0)) begin
      push       = 1'b1;
      wdata      = {1'b1, sel_r};
      pend_rel_d = req_r & ~(NKEYS'(1) << sel_r);
    end
`endif

    rd_ptr_d = pop  ? rd_ptr + AW'(1) : rd_ptr;
    wr_ptr_d = push ? wr_ptr + AW'(1) : wr_ptr;

    count_d = fifo_count;
    case ({push, pop})
      2'b10:   count_d = fifo_count + CNT_W'(1);
      2'b01:   count_d = fifo_count - CNT_W'(1);
      default: count_d = fifo_count;
    endcase

    // The new head may be the entry being written this same cycle.
    valid_d = (count_d != '0);
    head_d  = '0;
    if (valid_d) begin
      if (push && (wr_ptr == rd_ptr_d)) head_d = wdata;
      else                              head_d = mem[rd_ptr_d];
    end

    ovf_d = ovf;
    if (ovf_set)      ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      mem <= '{default: '0};
    end else if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      ovf        <= 1'b0;
      pend       <= '0;
      prev       <= '0;
      armed      <= 1'b0;
`ifdef KEY_RELEASE_EVT_EN
      pend_rel   <= '0;
`endif
    end else begin
      rd_ptr     <= rd_ptr_d;
      wr_ptr     <= wr_ptr_d;
      fifo_count <= count_d;
      key_valid  <= valid_d;
      key_code   <= head_d;
      ovf        <= ovf_d;
      pend       <= pend_d;
      prev       <= btn_ok;
      armed      <= 1'b1;
`ifdef KEY_RELEASE_EVT_EN
      pend_rel   <= pend_rel_d;
`endif
    end
  end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Consumes the 25-bit debounced button level vector from the button scan/debounce stage.
- Turns each 0→1 transition into a 5-bit key-index event and buffers events in a small FIFO.
- Presents events to the CPU-side I/O port with a valid/ready handshake, so a slow poller never loses a keypress.

Parameters:
- NKEYS, 25, number of key level inputs; key index range 0..NKEYS-1; must be ≤ 32.
- DEPTH, 8, FIFO entries; power of two, 2..32.
- CNT_W, 4, width of fifo_count; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  system clock
- RSTN  in  1  asynchronous reset, active-low
- btn_ok  in  NKEYS  debounced key levels, 1 = pressed; synchronous to clk
- key_ready  in  1  consumer accepts the head entry this cycle
- clr_ovf  in  1  synchronous clear of ovf
- key_valid  out  1  FIFO non-empty
- key_code  out  6  head entry; [4:0] key index, [5] release flag (0 without the optional feature)
- fifo_count  out  CNT_W  entries held, 0..DEPTH
- ovf  out  1  sticky: an edge was dropped or merged

Behaviour:
- Reset (RSTN=0, asynchronous) clears the following: FIFO, rd/wr pointers, fifo_count=0, key_valid=0, key_code=0, ovf=0, pend=0, prev=0, armed=0.
- First clock after reset release:
  - prev ← btn_ok, armed ← 1.
  - No edges are detected in this cycle, so keys held through reset generate no press event.
- Edge detect, when armed:
  - rise = btn_ok & ~prev.
  - prev ← btn_ok every cycle.
- Pending vector pend[NKEYS-1:0]:
  - req = pend | rise.
  - Each cycle, sel = lowest set index of req.
  - If req≠0 and push is permitted: write {1'b0, sel} to FIFO. pend ← req with bit sel cleared.
  - Otherwise: pend ← req.
  - A rise on a key whose pend bit is already 1 sets ovf; the two presses merge into one event.
- Push permitted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
- Pop: when key_valid && key_ready, the rd pointer advances.
- Same-cycle push+pop leaves count unchanged. A push into an empty FIFO makes the entry visible the next cycle.
- FIFO is show-ahead:
  - key_code is driven by the registered head entry and is stable while key_valid=1 and key_ready=0.
  - key_valid = (count ≠ 0). key_code = 0 when empty.
- Latency: a btn_ok bit rising in cycle N (with empty pend and non-full FIFO) gives key_valid=1 with the index in cycle N+1.
- Throughput: one push and one pop per cycle maximum.
- FIFO full:
  - New edges accumulate in pend, one per key, and are not lost.
  - They drain lowest-index-first as space frees.
- Pointers wrap modulo DEPTH. fifo_count saturates at DEPTH by construction; it never exceeds DEPTH.
- ovf:
  - Set on a merge or cancel event.
  - Cleared by clr_ovf; if set and clear coincide, set wins.
- Pointer and level edge inputs are not re-synchronised; btn_ok is already clk-domain.

Optional Feature:
- Macro: KEY_RELEASE_EVT_EN.
- Defined:
  - A second vector pend_rel, fed by fall = ~btn_ok & prev, generates release events written as {1'b1, index}.
  - Arbitration: any press request beats any release request; within each class, lowest index wins.
  - A rise on a key with pend_rel set cancels both the pending release and the new press, and sets ovf.
  - A fall on a key with pend set cancels both, and sets ovf.
  - Result: the queue never reports an event order inconsistent with the last delivered state.
- Undefined: no release logic is generated; key_code[5] is tied 0; falls are ignored.

Test Plan:
- Reset with btn_ok=25'h0000010 held, release RSTN, idle 5 cycles -> key_valid stays 0, fifo_count=0.
- key_ready=1; btn_ok bit 7 rises cycle N -> key_valid=1, key_code=6'd7 in cycle N+1; popped, count back to 0 in N+2.
- key_ready=0; bits 3, 0, 12 rise in the same cycle -> fifo_count steps 1, 2, 3 over three cycles; pops yield 0, 3, 12 in that order.
- key_ready=0; 10 distinct keys rise one per cycle, DEPTH=8 -> fifo_count=8, 2 pend bits held, ovf=0. Then key_ready=1 -> all 10 indices delivered in order, with no gap beyond one cycle.
- FIFO full and pend[5]=1; key 5 falls then rises again -> ovf=1, only one event for key 5 delivered. clr_ovf pulse -> ovf=0 next cycle.
- With KEY_RELEASE_EVT_EN defined: key 2 press then release, 4 cycles apart, key_ready=1 -> events 6'h02 then 6'h22. A mid-queue RSTN pulse -> key_valid=0 immediately (asynchronous), count=0.
